// File: rtl/ctrl_fsm_p.sv
// Multi-cycle control FSM for the 16-bit CR16-style datapath: fetch, decode,
// ALU execute, load/store, conditional branch/jump, jump-and-link and halt.
module ctrl_fsm_p #(
  parameter int DATA_W        = 16,
  parameter int NREG          = 16,
  parameter int RAM_LAT       = 1,
  parameter bit FLAG_ON_ARITH = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr_set,
  input  logic [4:0]        Flags_in,
  input  logic              resume,
  output logic [NREG-1:0]   wEnable,
  output logic [7:0]        opcode,
  output logic [3:0]        Rdest_select,
  output logic [3:0]        Rsrc_select,
  output logic [7:0]        Imm_in,
  output logic              Imm_select,
  output logic              we_a,
  output logic              en_a,
  output logic              ram_wen,
  output logic              lsc_mux_selct,
  output logic [DATA_W-1:0] pc_add_k,
  output logic [1:0]        pc_mux_selct,
  output logic              pc_en,
  output logic [1:0]        wb_sel,
  output logic [4:0]        saved_flags,
  output logic              halted
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, STORE, LOAD, DOUT, BRANCH, JUMP, JAL, HALT
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  wcnt, wcnt_nxt;
  logic        wcnt_last;
  logic        flag_we;
  logic [3:0]  hi_op, lo_op;
  logic        is_cmp, is_arith, latch_flags;
  logic        cond_true;
  logic [NREG-1:0] dest_onehot;

  assign hi_op        = instr_set[15:12];
  assign lo_op        = instr_set[7:4];
  assign opcode       = {hi_op, lo_op};
  assign Rdest_select = instr_set[11:8];
  assign Rsrc_select  = instr_set[3:0];
  assign Imm_in       = instr_set[7:0];
  assign Imm_select   = (hi_op != 4'h0) && (hi_op != 4'h4);

  assign wcnt_last = (wcnt == 2'(RAM_LAT - 1));

  assign is_cmp   = ((hi_op == 4'h0) && (lo_op == 4'hB)) || (hi_op == 4'hB);
  assign is_arith = ((hi_op == 4'h0) && (lo_op inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA}))
                 || (hi_op inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA});
  assign latch_flags = is_cmp || (FLAG_ON_ARITH && is_arith);

  // Shifting a one past the top bit leaves zero, so Rdest >= NREG writes nothing.
  assign dest_onehot = NREG'(1) << Rdest_select;

  // saved_flags = {L, C, F, Z, N}
  always_comb begin
    cond_true = 1'b0;
    case (Rdest_select)
      4'h0: cond_true =  saved_flags[1];
      4'h1: cond_true = !saved_flags[1];
      4'h2: cond_true =  saved_flags[3];
      4'h3: cond_true = !saved_flags[3];
      4'h4: cond_true =  saved_flags[4];
      4'h5: cond_true = !saved_flags[4];
      4'h6: cond_true =  saved_flags[0];
      4'h7: cond_true = !saved_flags[0];
      4'h8: cond_true =  saved_flags[2];
      4'h9: cond_true = !saved_flags[2];
      4'hA: cond_true = !saved_flags[4] && !saved_flags[1];
      4'hB: cond_true =  saved_flags[4] ||  saved_flags[1];
      4'hC: cond_true = !saved_flags[0] && !saved_flags[1];
      4'hD: cond_true =  saved_flags[0] ||  saved_flags[1];
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      saved_flags <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (flag_we) saved_flags <= Flags_in;
    end
  end

  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = '0;
    flag_we       = 1'b0;
    wEnable       = '0;
    we_a          = 1'b0;
    en_a          = 1'b0;
    ram_wen       = 1'b0;
    lsc_mux_selct = 1'b0;
    pc_add_k      = '0;
    pc_mux_selct  = 2'b00;
    pc_en         = 1'b0;
    wb_sel        = 2'b00;
    halted        = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        en_a = 1'b1;
        if (wcnt_last) state_nxt = DECODE;
        else           wcnt_nxt  = wcnt + 2'd1;
      end
      DECODE: begin
        casez (instr_set)
          16'b0100_????_0100_????: state_nxt = STORE;
          16'b0100_????_0000_????: state_nxt = LOAD;
          16'b0100_????_1100_????: state_nxt = JUMP;
          16'b0100_????_1000_????: state_nxt = JAL;
          16'b1100_????_????_????: state_nxt = BRANCH;
          16'b0000_????_0000_????: state_nxt = HALT;
          default:                 state_nxt = EXEC;
        endcase
      end
      EXEC: begin
        pc_en   = 1'b1;
        flag_we = latch_flags;
        if (!is_cmp) wEnable = dest_onehot;
        state_nxt = FETCH;
      end
      STORE: begin
        lsc_mux_selct = 1'b1;
        en_a          = 1'b1;
        we_a          = 1'b1;
        ram_wen       = 1'b1;
        pc_en         = 1'b1;
        state_nxt     = FETCH;
      end
      LOAD: begin
        lsc_mux_selct = 1'b1;
        en_a          = 1'b1;
        if (wcnt_last) state_nxt = DOUT;
        else           wcnt_nxt  = wcnt + 2'd1;
      end
      DOUT: begin
        lsc_mux_selct = 1'b1;
        wb_sel        = 2'b01;
        wEnable       = dest_onehot;
        pc_en         = 1'b1;
        state_nxt     = FETCH;
      end
      BRANCH: begin
        pc_en        = 1'b1;
        pc_add_k     = DATA_W'($signed(Imm_in));
        pc_mux_selct = cond_true ? 2'b01 : 2'b00;
        state_nxt    = FETCH;
      end
      JUMP: begin
        pc_en        = 1'b1;
        pc_mux_selct = cond_true ? 2'b10 : 2'b00;
        state_nxt    = FETCH;
      end
      JAL: begin
        pc_en        = 1'b1;
        pc_mux_selct = 2'b10;
        wb_sel       = 2'b10;
        wEnable      = dest_onehot;
        state_nxt    = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (resume) begin
          pc_en     = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm_p.sv
// Bench for ctrl_fsm_p: two configurations (RAM_LAT=1/FLAG_ON_ARITH=0 and
// RAM_LAT=3/FLAG_ON_ARITH=1/NREG=8), one active at a time, sharing stimulus.
module tb_ctrl_fsm_p;

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  flags;
    logic        res;
    int          cyc;   // 0 = not checked
    logic [15:0] wen;
    logic [1:0]  wb;
    logic [1:0]  pcm;
    logic [15:0] padd;
    logic        lsc;
    int          ena;
    int          rwen;
    logic        hlt;
    logic [4:0]  sf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_1, rst_3, sel;
  logic [15:0] instr;
  logic [4:0]  flags;
  logic        resume;

  logic [15:0] wen_1, padd_1, padd_3;
  logic [7:0]  wen_3, opc_1, opc_3, imm_1, imm_3;
  logic [3:0]  rd_1, rd_3, rs_1, rs_3;
  logic        isel_1, isel_3, we_1, we_3, ena_1, ena_3, rw_1, rw_3, lsc_1, lsc_3;
  logic        pce_1, pce_3, hlt_1, hlt_3;
  logic [1:0]  pcm_1, pcm_3, wb_1, wb_3;
  logic [4:0]  sf_1, sf_3;

  ctrl_fsm_p #(.DATA_W(16), .NREG(16), .RAM_LAT(1), .FLAG_ON_ARITH(1'b0)) u_dut1 (
    .clk(clk), .reset(rst_1), .instr_set(instr), .Flags_in(flags), .resume(resume),
    .wEnable(wen_1), .opcode(opc_1), .Rdest_select(rd_1), .Rsrc_select(rs_1),
    .Imm_in(imm_1), .Imm_select(isel_1), .we_a(we_1), .en_a(ena_1), .ram_wen(rw_1),
    .lsc_mux_selct(lsc_1), .pc_add_k(padd_1), .pc_mux_selct(pcm_1), .pc_en(pce_1),
    .wb_sel(wb_1), .saved_flags(sf_1), .halted(hlt_1));

  ctrl_fsm_p #(.DATA_W(16), .NREG(8), .RAM_LAT(3), .FLAG_ON_ARITH(1'b1)) u_dut3 (
    .clk(clk), .reset(rst_3), .instr_set(instr), .Flags_in(flags), .resume(resume),
    .wEnable(wen_3), .opcode(opc_3), .Rdest_select(rd_3), .Rsrc_select(rs_3),
    .Imm_in(imm_3), .Imm_select(isel_3), .we_a(we_3), .en_a(ena_3), .ram_wen(rw_3),
    .lsc_mux_selct(lsc_3), .pc_add_k(padd_3), .pc_mux_selct(pcm_3), .pc_en(pce_3),
    .wb_sel(wb_3), .saved_flags(sf_3), .halted(hlt_3));

  logic        m_rst, m_isel, m_we, m_ena, m_rw, m_lsc, m_pce, m_hlt;
  logic [15:0] m_wen, m_padd;
  logic [7:0]  m_opc, m_imm;
  logic [3:0]  m_rd;
  logic [1:0]  m_pcm, m_wb;
  logic [4:0]  m_sf;

  always_comb begin
    m_rst  = sel ? rst_3 : rst_1;
    m_wen  = sel ? {8'h00, wen_3} : wen_1;
    m_opc  = sel ? opc_3 : opc_1;
    m_rd   = sel ? rd_3 : rd_1;
    m_imm  = sel ? imm_3 : imm_1;
    m_isel = sel ? isel_3 : isel_1;
    m_we   = sel ? we_3 : we_1;
    m_ena  = sel ? ena_3 : ena_1;
    m_rw   = sel ? rw_3 : rw_1;
    m_lsc  = sel ? lsc_3 : lsc_1;
    m_padd = sel ? padd_3 : padd_1;
    m_pcm  = sel ? pcm_3 : pcm_1;
    m_pce  = sel ? pce_3 : pce_1;
    m_wb   = sel ? wb_3 : wb_1;
    m_sf   = sel ? sf_3 : sf_1;
    m_hlt  = sel ? hlt_3 : hlt_1;
  end

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  vec_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-instruction monitor: accumulates activity, compares on the pc_en pulse.
  int cnt = 0, ena_c = 0, rw_c = 0, wen_c = 0;
  always @(negedge clk) begin
    if (!m_rst) begin
      cnt = 0; ena_c = 0; rw_c = 0; wen_c = 0;
    end else begin
      cnt++;
      ena_c += int'(m_ena);
      rw_c  += int'(m_rw);
      wen_c += int'(m_wen != 16'h0);
      if (m_pce) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pc_en: got pc_en=1 want 0 (wEnable=%h)", m_wen);
        end else begin
          vec_t e;
          e = q.pop_front();
          if (e.cyc != 0) chk($sformatf("cycles@%h", e.instr), cnt, e.cyc);
          chk($sformatf("wEnable@%h", e.instr), m_wen, e.wen);
          chk($sformatf("wen_pulses@%h", e.instr), wen_c, (e.wen != 0) ? 1 : 0);
          chk($sformatf("wb_sel@%h", e.instr), m_wb, e.wb);
          chk($sformatf("pc_mux@%h", e.instr), m_pcm, e.pcm);
          chk($sformatf("pc_add_k@%h", e.instr), m_padd, e.padd);
          chk($sformatf("lsc@%h", e.instr), m_lsc, e.lsc);
          chk($sformatf("en_a_cycles@%h", e.instr), ena_c, e.ena);
          chk($sformatf("ram_wen_pulses@%h", e.instr), rw_c, e.rwen);
          chk($sformatf("halted@%h", e.instr), m_hlt, e.hlt);
          done_cnt++;
        end
        cnt = 0; ena_c = 0; rw_c = 0; wen_c = 0;
      end
    end
  end

  function automatic vec_t mk(input logic [15:0] i, input logic [4:0] f, input logic r,
                              input int c, input logic [15:0] w, input logic [1:0] wb,
                              input logic [1:0] pm, input logic [15:0] pa, input logic l,
                              input int ea, input int rw, input logic h, input logic [4:0] s);
    vec_t v;
    v.instr = i; v.flags = f; v.res = r; v.cyc = c; v.wen = w; v.wb = wb; v.pcm = pm;
    v.padd = pa; v.lsc = l; v.ena = ea; v.rwen = rw; v.hlt = h; v.sf = s;
    return v;
  endfunction

  task automatic wait_done(input int start, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_cnt != start) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got no pc_en want pc_en within 40 cycles", name);
      q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    instr = v.instr; flags = v.flags; resume = v.res;
    start = done_cnt;
    q.push_back(v);
    wait_done(start, $sformatf("%h", v.instr));
    @(posedge clk); #1;
    chk($sformatf("saved_flags@%h", v.instr), m_sf, v.sf);
    resume = 1'b0;
  endtask

  vec_t t1[19];
  vec_t t3[8];

  initial begin
    //              instr    flags    res  cyc wEnable  wb     pcm    pc_add_k lsc  en_a rw hlt sf
    t1[0]  = mk(16'h5305, 5'h00, 1'b0, 3, 16'h0008, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h00);
    t1[1]  = mk(16'h01B2, 5'h02, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h02);
    t1[2]  = mk(16'hC0FE, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b01, 16'hFFFE, 1'b0, 1, 0, 1'b0, 5'h02);
    t1[3]  = mk(16'h01B2, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h00);
    t1[4]  = mk(16'hC0FE, 5'h02, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'hFFFE, 1'b0, 1, 0, 1'b0, 5'h00);
    t1[5]  = mk(16'h4EC5, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b10, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h00);
    t1[6]  = mk(16'h4FC5, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h00);
    t1[7]  = mk(16'h4486, 5'h00, 1'b0, 3, 16'h0010, 2'b10, 2'b10, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h00);
    t1[8]  = mk(16'h0152, 5'h1F, 1'b0, 3, 16'h0002, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h00);
    t1[9]  = mk(16'h4347, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b1, 2, 1, 1'b0, 5'h00);
    t1[10] = mk(16'h4207, 5'h00, 1'b0, 4, 16'h0004, 2'b01, 2'b00, 16'h0000, 1'b1, 2, 0, 1'b0, 5'h00);
    t1[11] = mk(16'hB5FF, 5'h11, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h11);
    t1[12] = mk(16'hC603, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b01, 16'h0003, 1'b0, 1, 0, 1'b0, 5'h11);
    t1[13] = mk(16'hCA80, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'hFF80, 1'b0, 1, 0, 1'b0, 5'h11);
    t1[14] = mk(16'hCB7F, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b01, 16'h007F, 1'b0, 1, 0, 1'b0, 5'h11);
    t1[15] = mk(16'h47C1, 5'h00, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h11);
    t1[16] = mk(16'hC201, 5'h1F, 1'b0, 3, 16'h0000, 2'b00, 2'b00, 16'h0001, 1'b0, 1, 0, 1'b0, 5'h11);
    t1[17] = mk(16'h0000, 5'h00, 1'b1, 3, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b1, 5'h11);
    t1[18] = mk(16'h5305, 5'h00, 1'b1, 3, 16'h0008, 2'b00, 2'b00, 16'h0000, 1'b0, 1, 0, 1'b0, 5'h11);

    t3[0]  = mk(16'h4207, 5'h00, 1'b0, 8, 16'h0004, 2'b01, 2'b00, 16'h0000, 1'b1, 6, 0, 1'b0, 5'h00);
    t3[1]  = mk(16'h0152, 5'h1F, 1'b0, 5, 16'h0002, 2'b00, 2'b00, 16'h0000, 1'b0, 3, 0, 1'b0, 5'h1F);
    t3[2]  = mk(16'h5901, 5'h00, 1'b0, 5, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 3, 0, 1'b0, 5'h00);
    t3[3]  = mk(16'h01B2, 5'h02, 1'b0, 5, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 3, 0, 1'b0, 5'h02);
    t3[4]  = mk(16'h0112, 5'h1F, 1'b0, 5, 16'h0002, 2'b00, 2'b00, 16'h0000, 1'b0, 3, 0, 1'b0, 5'h02);
    t3[5]  = mk(16'hC1FE, 5'h00, 1'b0, 5, 16'h0000, 2'b00, 2'b00, 16'hFFFE, 1'b0, 3, 0, 1'b0, 5'h02);
    t3[6]  = mk(16'h4347, 5'h00, 1'b0, 5, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b1, 4, 1, 1'b0, 5'h02);
    t3[7]  = mk(16'h0000, 5'h00, 1'b1, 5, 16'h0000, 2'b00, 2'b00, 16'h0000, 1'b0, 3, 0, 1'b1, 5'h02);

    rst_1 = 1'b0; rst_3 = 1'b0; sel = 1'b0;
    instr = 16'h5305; flags = 5'h00; resume = 1'b0;

    // Reset state, with decode fields still following instr_set
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_en", m_pce, 0);
    chk("rst_wEnable", m_wen, 0);
    chk("rst_en_a", m_ena, 0);
    chk("rst_halted", m_hlt, 0);
    chk("rst_saved_flags", m_sf, 0);
    chk("rst_Rdest", m_rd, 4'h3);
    chk("rst_opcode", m_opc, 8'h50);
    chk("rst_Imm_in", m_imm, 8'h05);
    chk("rst_Imm_select", m_isel, 1'b1);
    #1 rst_1 = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(t1[i]);

    rst_1 = 1'b0; sel = 1'b1;
    @(negedge clk); #2 rst_3 = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(t3[i]);

    // WAIT held until resume
    begin
      int lat = -1;
      instr = 16'h0000; resume = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); #1;
        if (m_hlt) begin lat = i; break; end
      end
      chk("halt_latency", lat, 4);
      repeat (10) @(negedge clk);
      #1;
      chk("halt_hold", m_hlt, 1);
      chk("halt_no_pc_en", m_pce, 0);
      q.push_back(mk(16'h0000, 5'h00, 1'b1, 0, 16'h0000, 2'b00, 2'b00, 16'h0000,
                     1'b0, 3, 0, 1'b1, 5'h02));
      @(posedge clk); #1 resume = 1'b1;
      wait_done(done_cnt, "resume");
      @(posedge clk); #1 resume = 1'b0;
      chk("fetch_after_resume_en_a", m_ena, 1);
      chk("fetch_after_resume_halted", m_hlt, 0);
    end

    // Reset dropped while LOAD waits on RAM
    instr = 16'h4207;
    repeat (5) @(negedge clk);
    #1;
    chk("load_wait_en_a", m_ena, 1);
    chk("load_wait_lsc", m_lsc, 1);
    rst_3 = 1'b0;
    #1;
    chk("abort_en_a", m_ena, 0);
    chk("abort_lsc", m_lsc, 0);
    chk("abort_pc_en", m_pce, 0);
    chk("abort_wEnable", m_wen, 0);
    chk("abort_ram_wen", m_rw, 0);
    chk("abort_we_a", m_we, 0);
    chk("abort_wb_sel", m_wb, 0);
    chk("abort_saved_flags", m_sf, 0);
    chk("abort_Rdest_passthru", m_rd, 4'h2);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_held_pc_en", m_pce, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
